fpga_bram_responder: RTL and testbench

Memory-side responder for the FPGA BRAM link. Consumes the controller's show-ahead FIFO through the `mem` modport signals, decodes address and data beats into fixed-length read/write bursts, and drives an internal single-port BRAM. Returns read data and write acknowledgements on the memory-to-controller bus. Sits directly downstream of the controller FIFO and is the terminal stage of the memory path.

---
 rtl/fpga_bram_pkg.sv | 21 ++
 rtl/fpga_bram_array.sv | 29 ++
 rtl/fpga_bram_responder.sv | 148 ++++++++++++++
 tb/tb_fpga_bram_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_bram_pkg.sv
// Shared types and width helpers for the FPGA BRAM link responder.
package fpga_bram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_ISSUE,
    ST_RD_DRAIN
  } state_e;

  // Beat counter is at least one bit so a BURST_LEN of 1 still elaborates.
  function automatic int cnt_width(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fpga_bram_array.sv
// Single-port RAM, registered read (1-cycle latency), no reset on contents.
module fpga_bram_array
  import fpga_bram_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = idx_width(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    addra,
  input  logic [WIDTH-1:0] dina,
  input  logic             wea,
  input  logic             ena,
  output logic [WIDTH-1:0] douta
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ena) begin
      if (wea) begin
        mem[addra] <= dina;
      end else begin
        douta <= mem[addra];
      end
    end
  end

endmodule

// File: rtl/fpga_bram_responder.sv
// Memory-side responder: pops show-ahead FIFO, runs fixed-length bursts on a BRAM.
// Read data returns 2 cycles after the address pop; write ack 1 cycle after last beat.
module fpga_bram_responder
  import fpga_bram_pkg::*;
#(
  parameter int ADDRESS_DATA_WIDTH = 32,
  parameter int BURST_LEN          = 4,
  parameter int BRAM_DEPTH         = 1024,
  parameter int ADDR_LSB           = 2
) (
  input  logic                          fpga_clk,
  input  logic                          rst,
  input  logic [ADDRESS_DATA_WIDTH-1:0] address_data_bus_c_to_m,
  input  logic                          address_on_c_to_m,
  input  logic                          data_on_c_to_m,
  input  logic                          read_en_c_to_m,
  input  logic                          write_en_c_to_m,
  input  logic                          fifo_empty,
  output logic                          r_en,
  output logic [ADDRESS_DATA_WIDTH-1:0] address_data_bus_m_to_c,
  output logic                          resp_m_to_c,
  output logic                          error
);

  localparam int IW = idx_width(BRAM_DEPTH);
  localparam int CW = cnt_width(BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  state_e                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic                            oor_q, oor_d;
  logic                            error_q, error_d;
  logic                            resp_q, resp_d;
  logic                            rd_q, rd_d;

  logic                            pop, addr_beat, data_beat, wr_word, rd_word;
  logic                            head_oor;
  logic [IW-1:0]                   head_idx;
  logic                            ram_ena, ram_wea;
  logic [IW-1:0]                   ram_addr;
  logic [ADDRESS_DATA_WIDTH-1:0]   ram_dout;

  assign head_idx  = address_data_bus_c_to_m[ADDR_LSB +: IW];
  assign head_oor  = |(address_data_bus_c_to_m >> (ADDR_LSB + IW));
  assign addr_beat = address_on_c_to_m && !data_on_c_to_m;
  assign data_beat = data_on_c_to_m && !address_on_c_to_m;
  assign wr_word   = write_en_c_to_m && !read_en_c_to_m;
  assign rd_word   = read_en_c_to_m && !write_en_c_to_m;

  // Gated by reset so nothing is consumed while the block is held in reset.
  assign pop  = rst && !fifo_empty && (state_q == ST_IDLE || state_q == ST_WR_DATA);
  assign r_en = pop;

  assign ram_addr = idx_q + IW'(cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    oor_d   = oor_q;
    error_d = error_q;
    ram_ena = 1'b0;
    ram_wea = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          if (addr_beat && (wr_word || rd_word)) begin
            idx_d   = head_idx;
            oor_d   = head_oor;
            cnt_d   = '0;
            error_d = error_q | head_oor;
            state_d = wr_word ? ST_WR_DATA : ST_RD_ISSUE;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_WR_DATA: begin
        if (pop) begin
          if (data_beat && wr_word) begin
            // Out-of-range bursts still consume and count beats, but never write.
            ram_ena = !oor_q;
            ram_wea = !oor_q;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_BEAT) begin
              cnt_d   = '0;
              state_d = ST_WR_RESP;
            end
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_WR_RESP: state_d = ST_IDLE;
      ST_RD_ISSUE: begin
        ram_ena = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BEAT) begin
          cnt_d   = '0;
          state_d = ST_RD_DRAIN;
        end
      end
      ST_RD_DRAIN: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    resp_d = (state_d == ST_WR_RESP) || (state_q == ST_RD_ISSUE);
    rd_d   = (state_q == ST_RD_ISSUE);
  end

  always_ff @(posedge fpga_clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      error_q <= 1'b0;
      resp_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      error_q <= error_d;
      resp_q  <= resp_d;
      rd_q    <= rd_d;
    end
  end

  fpga_bram_array #(
    .WIDTH (ADDRESS_DATA_WIDTH),
    .DEPTH (BRAM_DEPTH),
    .AW    (IW)
  ) u_array (
    .clk   (fpga_clk),
    .addra (ram_addr),
    .dina  (address_data_bus_c_to_m),
    .wea   (ram_wea),
    .ena   (ram_ena),
    .douta (ram_dout)
  );

  assign address_data_bus_m_to_c = (rd_q && !oor_q) ? ram_dout : '0;
  assign resp_m_to_c             = resp_q;
  assign error                   = error_q;

endmodule

// File: tb/tb_fpga_bram_responder.sv
// Directed bench: show-ahead FIFO model feeding the responder, response log checked against hand values.
module tb_fpga_bram_responder;

  logic        fpga_clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address_data_bus_c_to_m = '0;
  logic        address_on_c_to_m = 1'b0;
  logic        data_on_c_to_m = 1'b0;
  logic        read_en_c_to_m = 1'b0;
  logic        write_en_c_to_m = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        r_en;
  logic [31:0] address_data_bus_m_to_c;
  logic        resp_m_to_c;
  logic        error;

  typedef struct packed {
    logic [31:0] w;
    logic        a;
    logic        d;
    logic        rd;
    logic        wr;
  } word_t;

  word_t       fq[$];
  logic [31:0] rq[$];
  int          rc[$];
  int          pc[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        stall = 1'b0;
  logic        stall_mode = 1'b0;
  logic        ren_s = 1'b0;

  fpga_bram_responder dut (
    .fpga_clk                (fpga_clk),
    .rst                     (rst),
    .address_data_bus_c_to_m (address_data_bus_c_to_m),
    .address_on_c_to_m       (address_on_c_to_m),
    .data_on_c_to_m          (data_on_c_to_m),
    .read_en_c_to_m          (read_en_c_to_m),
    .write_en_c_to_m         (write_en_c_to_m),
    .fifo_empty              (fifo_empty),
    .r_en                    (r_en),
    .address_data_bus_m_to_c (address_data_bus_m_to_c),
    .resp_m_to_c             (resp_m_to_c),
    .error                   (error)
  );

  always #5 fpga_clk = ~fpga_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic update_drive();
    if (fq.size() == 0 || stall) begin
      fifo_empty              = 1'b1;
      address_data_bus_c_to_m = '0;
      address_on_c_to_m       = 1'b0;
      data_on_c_to_m          = 1'b0;
      read_en_c_to_m          = 1'b0;
      write_en_c_to_m         = 1'b0;
    end else begin
      fifo_empty              = 1'b0;
      address_data_bus_c_to_m = fq[0].w;
      address_on_c_to_m       = fq[0].a;
      data_on_c_to_m          = fq[0].d;
      read_en_c_to_m          = fq[0].rd;
      write_en_c_to_m         = fq[0].wr;
    end
  endtask

  // FIFO pop on the edge where r_en was seen high just before it.
  always @(posedge fpga_clk) begin
    word_t tmp;
    if (ren_s && fq.size() > 0) begin
      tmp = fq.pop_front();
      pc.push_back(cyc);
    end
    #1;
    stall = stall_mode ? ~stall : 1'b0;
    update_drive();
  end

  always @(negedge fpga_clk) begin
    cyc++;
    if (resp_m_to_c) begin
      rq.push_back(address_data_bus_m_to_c);
      rc.push_back(cyc);
    end
    #2 ren_s = r_en;
  end

  task automatic step();
    @(negedge fpga_clk);
    #1;
  endtask

  task automatic push_addr(input logic [31:0] addr, input logic is_wr);
    fq.push_back('{w: addr, a: 1'b1, d: 1'b0, rd: !is_wr, wr: is_wr});
    update_drive();
  endtask

  task automatic push_data(input logic [31:0] dat, input logic is_wr);
    fq.push_back('{w: dat, a: 1'b0, d: 1'b1, rd: !is_wr, wr: is_wr});
    update_drive();
  endtask

  task automatic clear_logs();
    rq.delete();
    rc.delete();
    pc.delete();
  endtask

  task automatic wait_resp(input int n, input int budget);
    int k = 0;
    while (rq.size() < n && k < budget) begin
      step();
      k++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got cyc %0d exp finish", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] exp3 [10];

    // Reset state with a word already waiting at the FIFO head.
    push_addr(32'h100, 1'b1);
    for (int i = 0; i < 4; i++) push_data(32'hA0 + i, 1'b1);
    push_addr(32'h100, 1'b0);
    repeat (3) step();
    chk("rst_r_en", {31'd0, r_en}, 32'd0);
    chk("rst_resp", {31'd0, resp_m_to_c}, 32'd0);
    chk("rst_bus", address_data_bus_m_to_c, 32'd0);
    chk("rst_err", {31'd0, error}, 32'd0);
    rst = 1'b1;

    // Write burst then read back with timing.
    wait_resp(5, 40);
    repeat (3) step();
    chk("t1_cnt", rq.size(), 5);
    chk("t1_pops", pc.size(), 6);
    chk("t1_ack", rq[0], 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("t1_rd%0d", i), rq[i+1], 32'hA0 + i);
    chk("t1_beat_gap", pc[4] - pc[1], 3);
    chk("t1_ack_cyc", rc[0], pc[4] + 1);
    chk("t1_rdpop_cyc", pc[5], pc[4] + 2);
    chk("t1_rd_first", rc[1], pc[5] + 2);
    chk("t1_rd_last", rc[4], pc[5] + 5);
    chk("t1_err", {31'd0, error}, 32'd0);

    // Write with the FIFO going empty every other cycle.
    clear_logs();
    stall_mode = 1'b1;
    push_addr(32'h200, 1'b1);
    for (int i = 0; i < 4; i++) push_data(32'hB0 + i, 1'b1);
    wait_resp(1, 60);
    stall_mode = 1'b0;
    repeat (3) step();
    chk("t2_ack_cnt", rq.size(), 1);
    chk("t2_ack", rq[0], 32'd0);
    chk("t2_pops", pc.size(), 5);
    chk("t2_beat_gap", pc[4] - pc[1], 6);
    chk("t2_ack_cyc", rc[0], pc[4] + 1);
    clear_logs();
    push_addr(32'h200, 1'b0);
    wait_resp(4, 40);
    repeat (3) step();
    chk("t2_rd_cnt", rq.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_rd%0d", i), rq[i], 32'hB0 + i);

    // Burst at index 1022 wraps onto indices 0 and 1.
    clear_logs();
    push_addr(32'h0, 1'b1);
    for (int i = 0; i < 4; i++) push_data(32'hD0 + i, 1'b1);
    push_addr(32'hFF8, 1'b1);
    for (int i = 0; i < 4; i++) push_data(32'hC0 + i, 1'b1);
    push_addr(32'h0, 1'b0);
    push_addr(32'hFF8, 1'b0);
    exp3 = '{32'h0, 32'h0, 32'hC2, 32'hC3, 32'hD2, 32'hD3, 32'hC0, 32'hC1, 32'hC2, 32'hC3};
    wait_resp(10, 80);
    repeat (3) step();
    chk("t3_cnt", rq.size(), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("t3_r%0d", i), rq[i], exp3[i]);
    chk("t3_err", {31'd0, error}, 32'd0);

    // Stray data beat in IDLE, then an out-of-range read.
    clear_logs();
    push_data(32'hDEAD, 1'b1);
    repeat (3) step();
    chk("t4_err_set", {31'd0, error}, 32'd1);
    chk("t4_no_resp", rq.size(), 0);
    push_addr(32'h1000, 1'b0);
    wait_resp(4, 40);
    repeat (3) step();
    chk("t4_oor_cnt", rq.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_oor%0d", i), rq[i], 32'd0);
    clear_logs();
    push_addr(32'h100, 1'b0);
    wait_resp(4, 40);
    repeat (3) step();
    for (int i = 0; i < 4; i++) chk($sformatf("t4_rd%0d", i), rq[i], 32'hA0 + i);
    chk("t4_err_held", {31'd0, error}, 32'd1);

    // Reset in the middle of a read burst.
    clear_logs();
    push_addr(32'h100, 1'b0);
    wait_resp(2, 40);
    chk("t5_mid_resp", rq.size(), 2);
    rst = 1'b0;
    #1;
    chk("t5_rst_resp", {31'd0, resp_m_to_c}, 32'd0);
    chk("t5_rst_bus", address_data_bus_m_to_c, 32'd0);
    chk("t5_rst_err", {31'd0, error}, 32'd0);
    repeat (2) step();
    rst = 1'b1;
    clear_logs();
    repeat (6) step();
    chk("t5_abandon", rq.size(), 0);
    push_addr(32'h0, 1'b1);
    for (int i = 0; i < 4; i++) push_data(32'hE0 + i, 1'b1);
    push_addr(32'h0, 1'b0);
    push_addr(32'h100, 1'b0);
    wait_resp(9, 80);
    repeat (3) step();
    chk("t5_cnt", rq.size(), 9);
    chk("t5_ack", rq[0], 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("t5_new%0d", i), rq[i+1], 32'hE0 + i);
    for (int i = 0; i < 4; i++) chk($sformatf("t5_old%0d", i), rq[i+5], 32'hA0 + i);
    chk("t5_err", {31'd0, error}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
